sort_out_stream: RTL and testbench
==================================

SORT_OUT_STREAM -- requirements
Module: sort_out_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every element and of dout.
REQ-002 Parameter: CNTW, default 16, width of frame_cnt.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: load  input  1  capture request for one sorted frame.
REQ-007 Port: desc  input  1  order select, sampled with load: 0 = emit din1 first, 1 = emit din8 first.
REQ-008 Port: din1..din8  input  WIDTH each  sorted frame (din1 smallest) from the upstream 8-element sorter.
REQ-009 Port: busy  output  1  frame held, streaming not yet complete.
REQ-010 Port: dout  output  WIDTH  current stream element.
REQ-011 Port: dout_valid  output  1  dout carries a valid element.
REQ-012 Port: dout_ready  input  1  downstream accepts dout this cycle.
REQ-013 Port: dout_last  output  1  current element is the 8th of the frame.
REQ-014 Port: frame_cnt  output  CNTW  completed frames since reset.

Function
REQ-015 The block SHALL use two states: IDLE (busy=0, dout_valid=0) and SEND (busy=1, dout_valid=1).
REQ-016 In IDLE with load=1, the block SHALL register din1..din8 and desc into an internal 8-entry buffer, clear the index to 0, and enter SEND on the next edge.
REQ-017 dout_valid SHALL assert on the first cycle after the accepting load edge (1-cycle latency, load to first valid).
REQ-018 In SEND, dout SHALL be buffer[index] when desc_latched=0 and buffer[7-index] when desc_latched=1; index is a 3-bit counter.
REQ-019 A transfer SHALL occur on an edge where dout_valid=1 and dout_ready=1; on each transfer, index increments by 1.
REQ-020 While dout_valid=1 and dout_ready=0, dout, dout_last and index SHALL hold stable; no element is skipped or repeated.
REQ-021 dout_last SHALL equal 1 exactly when in SEND with index=7.
REQ-022 On the transfer with dout_last=1, the block SHALL return to IDLE and increment frame_cnt by 1 on the same edge; dout_valid deasserts the following cycle.
REQ-023 frame_cnt SHALL wrap from 2^CNTW-1 to 0 without saturation.
REQ-024 load while in SEND, including the cycle of the last transfer, SHALL be ignored; buffer and desc_latched remain unchanged.
REQ-025 din1..din8 and desc SHALL be don't-care outside the accepting load cycle.
REQ-026 Minimum frame period at dout_ready=1 continuously SHALL be 9 cycles: 1 load cycle plus 8 transfer cycles.
REQ-027 In IDLE, dout SHALL hold its last driven value, and dout_last SHALL be 0.
REQ-028 Element values SHALL pass through unmodified; the block performs no comparison or arithmetic on data.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE and set busy=0, dout_valid=0, dout_last=0, dout=0, index=0, frame_cnt=0.
REQ-030 rst SHALL take priority over load and over any transfer in the same cycle.
REQ-031 Reset in SEND SHALL abort the frame without incrementing frame_cnt; the first load after rst deasserts is accepted normally.
REQ-032 Buffer contents after reset SHALL be unspecified and unobservable until the next accepted load.

Verification
REQ-033 Ascending, always ready: din=1,2,...,8, desc=0, load 1 cycle -> dout 1..8 on 8 consecutive cycles, dout_last only with 8, frame_cnt=1, busy low on cycle 10.
REQ-034 Descending: din=0x05,0x10,0x22,0x30,0x41,0x7F,0x80,0xFF, desc=1 -> dout FF,80,7F,41,30,22,10,05, with dout_last on 05.
REQ-035 Backpressure: dout_ready low for 3 cycles while dout=3 -> dout stays 3 with dout_valid=1, then 4 follows; all 8 elements are delivered exactly once.
REQ-036 Load during SEND: a second load with din=0xAA... at element 5 -> ignored, and the first frame completes unchanged; a load after busy falls is accepted.
REQ-037 Reset mid-frame: rst after 4 transfers -> next cycle dout_valid=0, dout=0, frame_cnt unchanged at its prior value (0 if first frame); a new load then streams a full 8 elements.
REQ-038 Wrap: with CNTW=2, 4 completed frames -> frame_cnt reads 1,2,3,0.

Source files
------------

// File: rtl/sort_out_stream.sv
// sort_out_stream: captures one 8-element sorted frame and replays it one
// element per transfer over a valid/ready stream, in ascending or descending
// order. Data passes through untouched; a wrapping counter tracks completed
// frames.
module sort_out_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             desc,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    input  logic [WIDTH-1:0] din6,
    input  logic [WIDTH-1:0] din7,
    input  logic [WIDTH-1:0] din8,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic [CNTW-1:0]  frame_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e           state_q;
    state_e           state_d;

    logic [WIDTH-1:0] din_a [8];
    logic [WIDTH-1:0] buf_q [8];
    logic             desc_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_n;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] next_elem;
    logic [CNTW-1:0]  cnt_q;

    logic             accept;
    logic             xfer;
    logic             at_last;

    // Gather the frame inputs into an indexable array.
    always_comb begin
        din_a[0] = din1;
        din_a[1] = din2;
        din_a[2] = din3;
        din_a[3] = din4;
        din_a[4] = din5;
        din_a[5] = din6;
        din_a[6] = din7;
        din_a[7] = din8;
    end

    // Handshake qualifiers; a load is only honoured while idle.
    always_comb begin
        accept  = (state_q == StIdle) && load;
        xfer    = (state_q == StSend) && dout_ready;
        at_last = (state_q == StSend) && (idx_q == 3'd7);
    end

    // Element that follows the current one; descending order reads from the top.
    always_comb begin
        idx_n     = idx_q + 3'd1;
        next_elem = desc_q ? buf_q[~idx_n] : buf_q[idx_n];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SEND only on the transfer of the eighth element.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (dout_ready && (idx_q == 3'd7)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the state and index.
    always_comb begin
        busy       = (state_q == StSend);
        dout_valid = (state_q == StSend);
        dout_last  = at_last;
    end

    // Frame buffer; contents are only observable after an accepted load, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= din_a[i];
            end
        end
    end

    // Stream datapath: index, order latch, output element and frame counter.
    // dout is registered so it already shows the next element on the cycle after
    // a transfer and simply holds once the frame is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_q <= 1'b0;
            idx_q  <= 3'd0;
            dout_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            desc_q <= desc;
            idx_q  <= 3'd0;
            dout_q <= desc ? din8 : din1;
        end else if (xfer) begin
            idx_q <= idx_n;
            if (at_last) begin
                cnt_q <= cnt_q + CNTW'(1);
            end else begin
                dout_q <= next_elem;
            end
        end
    end

    assign dout      = dout_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sort_out_stream.sv
// Directed bench for sort_out_stream (instantiated with CNTW=2 so the frame
// counter wrap is reachable).
module tb_sort_out_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       desc;
    logic [7:0] din1, din2, din3, din4, din5, din6, din7, din8;
    logic       busy;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic [1:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    sort_out_stream #(
        .WIDTH(8),
        .CNTW (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .desc      (desc),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .din4      (din4),
        .din5      (din5),
        .din6      (din6),
        .din7      (din7),
        .din8      (din8),
        .busy      (busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_din(input logic [7:0] a, b, c, d, e, f, g, h);
        din1 = a; din2 = b; din3 = c; din4 = d;
        din5 = e; din6 = f; din7 = g; din8 = h;
    endtask

    // One-cycle load pulse; returns 1 ns into the first SEND cycle.
    task automatic do_load(input logic d);
        @(posedge clk); #1;
        load = 1'b1;
        desc = d;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; desc = 1'b0; dout_ready = 1'b1;
        set_din(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
        total++; if (dout_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", dout_last); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", dout); end
        total++; if (frame_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt); end
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e [8];
        e[0] = 8'h01; e[1] = 8'h02; e[2] = 8'h03; e[3] = 8'h04;
        e[4] = 8'h05; e[5] = 8'h06; e[6] = 8'h07; e[7] = 8'h08;
        set_din(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88);
        dout_ready = 1'b1;
        do_load(1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (dout !== 8'h55) begin bad++; $display("FAIL mid_before_rst: got %h want 55", dout); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", dout_valid); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_rst_dout: got %h want 00", dout); end
        total++; if (frame_cnt !== 2'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", frame_cnt); end
        set_din(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
        do_load(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || dout !== e[i]) begin
                bad++; $display("FAIL mid_new[%0d]: got v=%b %h want v=1 %h", i, dout_valid, dout, e[i]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (frame_cnt !== 2'd1) begin bad++; $display("FAIL mid_new_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_ascending();
        logic [7:0] e [8];
        e[0] = 8'd1; e[1] = 8'd2; e[2] = 8'd3; e[3] = 8'd4;
        e[4] = 8'd5; e[5] = 8'd6; e[6] = 8'd7; e[7] = 8'd8;
        set_din(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        dout_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== e[i] || dout_last !== (i == 7)) begin
                bad++;
                $display("FAIL asc[%0d]: got v=%b b=%b d=%h l=%b want v=1 b=1 d=%h l=%b",
                         i, dout_valid, busy, dout, dout_last, e[i], (i == 7));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin bad++; $display("FAIL asc_idle: got b=%b v=%b want 0 0", busy, dout_valid); end
        total++; if (dout !== 8'd8 || dout_last !== 1'b0) begin bad++; $display("FAIL asc_hold: got d=%h l=%b want 08 0", dout, dout_last); end
        total++; if (frame_cnt !== 2'd2) begin bad++; $display("FAIL asc_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_descending();
        logic [7:0] e [8];
        e[0] = 8'hFF; e[1] = 8'h80; e[2] = 8'h7F; e[3] = 8'h41;
        e[4] = 8'h30; e[5] = 8'h22; e[6] = 8'h10; e[7] = 8'h05;
        set_din(8'h05, 8'h10, 8'h22, 8'h30, 8'h41, 8'h7F, 8'h80, 8'hFF);
        dout_ready = 1'b1;
        do_load(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || dout !== e[i] || dout_last !== (i == 7)) begin
                bad++;
                $display("FAIL desc[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, dout_valid, dout, dout_last, e[i], (i == 7));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (frame_cnt !== 2'd3) begin bad++; $display("FAIL desc_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e [8];
        e[0] = 8'd1; e[1] = 8'd2; e[2] = 8'd3; e[3] = 8'd4;
        e[4] = 8'd5; e[5] = 8'd6; e[6] = 8'd7; e[7] = 8'd8;
        set_din(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        dout_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || dout !== e[i]) begin
                bad++; $display("FAIL bp[%0d]: got v=%b d=%h want v=1 d=%h", i, dout_valid, dout, e[i]);
            end
            if (i == 2) begin
                dout_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    total++;
                    if (dout_valid !== 1'b1 || dout !== 8'd3 || dout_last !== 1'b0) begin
                        bad++;
                        $display("FAIL bp_stall[%0d]: got v=%b d=%h l=%b want v=1 d=03 l=0",
                                 s, dout_valid, dout, dout_last);
                    end
                end
                dout_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", busy); end
        total++; if (frame_cnt !== 2'd0) begin bad++; $display("FAIL bp_cnt_wrap: got %0d want 0", frame_cnt); end
    endtask

    task automatic test_load_during_send();
        logic [7:0] e [8];
        logic [7:0] f [8];
        e[0] = 8'd1; e[1] = 8'd2; e[2] = 8'd3; e[3] = 8'd4;
        e[4] = 8'd5; e[5] = 8'd6; e[6] = 8'd7; e[7] = 8'd8;
        f[0] = 8'hC8; f[1] = 8'hC7; f[2] = 8'hC6; f[3] = 8'hC5;
        f[4] = 8'hC4; f[5] = 8'hC3; f[6] = 8'hC2; f[7] = 8'hC1;
        set_din(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        dout_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < 8; i++) begin
            // Stray loads at element 5 and on the final transfer must be ignored.
            if (i == 4 || i == 7) begin
                load = 1'b1; desc = 1'b1;
                set_din(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
            end
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || dout !== e[i]) begin
                bad++; $display("FAIL lds[%0d]: got v=%b d=%h want v=1 d=%h", i, dout_valid, dout, e[i]);
            end
            @(posedge clk); #1;
            load = 1'b0;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lds_idle: got %b want 0", busy); end
        total++; if (frame_cnt !== 2'd1) begin bad++; $display("FAIL lds_cnt: got %0d want 1", frame_cnt); end
        set_din(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8);
        do_load(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || dout !== f[i]) begin
                bad++; $display("FAIL lds_next[%0d]: got v=%b d=%h want v=1 d=%h", i, dout_valid, dout, f[i]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (frame_cnt !== 2'd2) begin bad++; $display("FAIL lds_next_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [1:0] ec [4];
        ec[0] = 2'd1; ec[1] = 2'd2; ec[2] = 2'd3; ec[3] = 2'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_din(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2);
            do_load(1'b0);
            repeat (8) @(posedge clk);
            @(negedge clk);
            total++;
            if (frame_cnt !== ec[k] || busy !== 1'b0) begin
                bad++; $display("FAIL wrap[%0d]: got cnt=%0d b=%b want cnt=%0d b=0", k, frame_cnt, busy, ec[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_ascending();
        test_descending();
        test_backpressure();
        test_load_during_send();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
